// File: rtl/fp_soc_hex_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver for the hex-digits PIO value.
// Round-robin digit scan with per-frame shadow latch, inter-digit guard, zero blanking and blink.
module fp_soc_hex_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    enable,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done,
    output logic [1:0]              dbg_state_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [FW-1:0]           fcnt_q, fcnt_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fd_q, fd_d;

    logic                    slot_end, frame_end;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [3:0]              nibble;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (state_q == ST_DRIVE) && (div_q == DW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            fcnt_q   <= '0;
            phase_q  <= 1'b0;
            seg_q    <= 7'h7F;
            sel_q    <= '1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            fcnt_q   <= fcnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            fd_q     <= fd_d;
        end
    end

    // Next-state logic; dropping enable parks the scan but keeps the blink cadence.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;
        if (!enable) begin
            state_d = ST_IDLE;
            div_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_GUARD;
                    div_d    = '0;
                    idx_d    = '0;
                    shadow_d = value_in;
                end
                ST_GUARD: begin
                    div_d = div_q + DW'(1);
                    if (div_q == DW'(GUARD - 1)) state_d = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state_d = ST_GUARD;
                        div_d   = '0;
                        idx_d   = frame_end ? '0 : idx_q + IW'(1);
                        if (frame_end) begin
                            shadow_d = value_in;
                            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                                fcnt_d  = '0;
                                phase_d = ~phase_q;
                            end else begin
                                fcnt_d = fcnt_q + FW'(1);
                            end
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A digit is zero-blanked when it and every more significant nibble is zero.
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_blank && zero_run && (i != 0);
        end
    end

    assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

    // Output decode, registered one edge later.
    always_comb begin
        seg_d = 7'h7F;
        sel_d = '1;
        fd_d  = enable && frame_end;
        if (enable && (state_q == ST_DRIVE)) begin
            sel_d[idx_q] = 1'b0;
            if (!(blink_en && phase_q) && !lz_dark[idx_q]) seg_d = ~hex_decode(nibble);
        end
    end

    assign seg_n       = seg_q;
    assign digit_sel_n = sel_q;
    assign frame_done  = fd_q;
    assign dp_n        = 1'b1;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_soc_hex_scan_driver.sv
// Directed plus randomized bench for fp_soc_hex_scan_driver against a position-based display model.
module tb_fp_soc_hex_scan_driver;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        enable = 1'b0;
    logic        lz_blank = 1'b0;
    logic        blink_en = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  digit_sel_n;
    logic        frame_done;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    // Reference model: cycles elapsed since the scan started, value latched per frame, frames seen.
    bit          run_m = 1'b0;
    int          n_m = 0;
    logic [15:0] frame_val = 16'h0;
    int          frames_total = 0;
    logic [6:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_fd;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    fp_soc_hex_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .enable(enable),
        .lz_blank(lz_blank), .blink_en(blink_en), .seg_n(seg_n), .dp_n(dp_n),
        .digit_sel_n(digit_sel_n), .frame_done(frame_done), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int pos, slot, off;
        logic [3:0] nib;
        @(posedge clk);
        e_seg = 7'h7F;
        e_sel = 4'hF;
        e_fd  = 1'b0;
        if (!enable) begin
            run_m = 1'b0;
        end else if (!run_m) begin
            run_m     = 1'b1;
            n_m       = 0;
            frame_val = value_in;
        end else begin
            n_m++;
            pos  = n_m - 1;
            slot = (pos / SD) % N;
            off  = pos % SD;
            nib  = frame_val[4*slot +: 4];
            if (off >= GD) begin
                e_sel[slot] = 1'b0;
                if (!(blink_en && ((frames_total / BF) % 2 == 1)) &&
                    !(lz_blank && slot > 0 && (frame_val >> (4 * slot)) == 16'h0))
                    e_seg = ~seg_tab[nib];
            end
            if (pos % (SD * N) == SD * N - 1) begin
                e_fd      = 1'b1;
                frame_val = value_in;
                frames_total++;
            end
        end
        #1;
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("digit_sel_n", 32'(digit_sel_n), 32'(e_sel));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("dp_n", 32'(dp_n), 32'd1);
    endtask

    task automatic model_reset();
        run_m        = 1'b0;
        n_m          = 0;
        frame_val    = 16'h0;
        frames_total = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg_n", 32'(seg_n), 32'h7F);
        check("rst_digit_sel_n", 32'(digit_sel_n), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_dp_n", 32'(dp_n), 32'd1);
        reset_n = 1'b1;
        model_reset();
        step();

        // Basic scan of 1234
        value_in = 16'h1234;
        enable   = 1'b1;
        step();
        repeat (3) step();
        check("slot0_seg", 32'(seg_n), 32'h19);
        check("slot0_sel", 32'(digit_sel_n), 32'hE);
        repeat (24) step();
        check("slot3_seg", 32'(seg_n), 32'h79);
        check("slot3_sel", 32'(digit_sel_n), 32'h7);
        repeat (5) step();
        check("frame_done_32", 32'(frame_done), 32'd1);
        repeat (40) step();

        // Asynchronous reset while a digit is being driven
        #2 reset_n = 1'b0;
        #1;
        check("arst_seg_n", 32'(seg_n), 32'h7F);
        check("arst_digit_sel_n", 32'(digit_sel_n), 32'hF);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        enable  = 1'b0;
        reset_n = 1'b1;
        model_reset();
        step();

        // Mid-frame value change is deferred to the next frame
        value_in = 16'h1234;
        enable   = 1'b1;
        step();
        repeat (14) step();
        value_in = 16'hABCD;
        repeat (18) step();
        repeat (3) step();
        check("abcd_slot0_seg", 32'(seg_n), 32'h21);
        repeat (40) step();

        // Leading-zero blanking
        enable = 1'b0;
        step();
        value_in = 16'h0070;
        lz_blank = 1'b1;
        enable   = 1'b1;
        step();
        repeat (3) step();
        check("lz_digit0_seg", 32'(seg_n), 32'h40);
        repeat (8) step();
        check("lz_digit1_seg", 32'(seg_n), 32'h78);
        check("lz_digit1_sel", 32'(digit_sel_n), 32'hD);
        repeat (60) step();

        // Blink across several frames
        lz_blank = 1'b0;
        blink_en = 1'b1;
        repeat (160) step();

        // Enable dropped at slot 2 cycle 4, then restart from digit 0
        blink_en = 1'b0;
        enable   = 1'b0;
        step();
        enable = 1'b1;
        step();
        repeat (21) step();
        enable = 1'b0;
        step();
        check("drop_seg", 32'(seg_n), 32'h7F);
        check("drop_sel", 32'(digit_sel_n), 32'hF);
        enable = 1'b1;
        step();
        repeat (3) step();
        check("restart_sel", 32'(digit_sel_n), 32'hE);
        check("restart_seg", 32'(seg_n), 32'h40);
        repeat (10) step();

        // Randomized traffic
        repeat (500) begin
            if ($urandom_range(0, 15) == 0) value_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if (enable && $urandom_range(0, 79) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
